if_pc_unit: RTL and testbench
=============================

IF_PC_UNIT -- requirements
Module: if_pc_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-003 stall  input  1  hazard stall from hazard unit; PC holds when asserted.
REQ-004 redirect  input  1  branch/jump taken, resolved in D stage.
REQ-005 redirect_pc  input  32  branch/jump target from D stage.
REQ-006 branch_D  input  1  instruction currently in D is a branch/jump.
REQ-007 exc_req  input  1  CP0 exception/interrupt entry request from M stage.
REQ-008 eret_req  input  1  ERET committing; return to EPC.
REQ-009 epc  input  32  CP0 EPC value.
REQ-010 instr_in  input  32  instruction word read from IM at iaddr.
REQ-011 iaddr  output  32  IM word address (equals pc_F).
REQ-012 pc_F  output  32  PC of instruction in F.
REQ-013 instr_F  output  32  instruction to IF/ID register.
REQ-014 exccode_F  output  5  fetch exception code (0 = none).
REQ-015 bd_F  output  1  instruction in F is a delay slot.
REQ-016 fetch_cnt  output  32  count of cycles the PC advanced.

Function
REQ-017 pc_F SHALL be a 32-bit register; iaddr SHALL equal pc_F combinationally.
REQ-018 Next-PC priority on each posedge: reset > exc_req > eret_req > stall > redirect > pc_F+4.
REQ-019 exc_req SHALL load 0x0000_4180 regardless of stall, redirect or eret_req.
REQ-020 eret_req (no exc_req) SHALL load epc regardless of stall or redirect.
REQ-021 stall (no exc_req/eret_req) SHALL hold pc_F, fetch_cnt and bd register unchanged.
REQ-022 redirect (no higher event) SHALL load redirect_pc; otherwise pc_F+4, wrapping mod 2^32.
REQ-023 Fetch address error: pc_F[1:0]!=0, or pc_F<0x0000_3000, or pc_F>0x0000_6FFC -> exccode_F=5'd4 (AdEL), else 0.
REQ-024 When exccode_F!=0, instr_F SHALL be 0x0000_0000; else instr_F=instr_in.
REQ-025 bd register SHALL load branch_D on a plain advance (PC+4 or redirect), clear on exc_req/eret_req, hold on stall; bd_F is the register output.
REQ-026 fetch_cnt SHALL increment by 1 on every advance (PC+4, redirect, exc_req, eret_req) and wrap 0xFFFF_FFFF->0.
REQ-027 All outputs SHALL be valid combinationally from registers and instr_in within the cycle; next-PC latency is one cycle.
REQ-028 redirect with misaligned/out-of-range redirect_pc SHALL still be loaded; error flagged next cycle via REQ-023.
REQ-029 exc_req and eret_req together: exc_req wins, PC=0x4180, bd cleared.

Reset
REQ-030 On reset: pc_F=0x0000_3000, bd=0, fetch_cnt=0; exccode_F=0, instr_F=instr_in.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL override all inputs that cycle.
REQ-032 No initial blocks are relied on; reset is the sole initialization path.

Verification
REQ-033 Reset, then 3 free cycles -> pc_F 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt=3.
REQ-034 pc_F=0x3010, stall=1 for 2 cycles with redirect=1 -> pc_F stays 0x3010, fetch_cnt unchanged; release -> sequence resumes.
REQ-035 pc_F=0x3020, branch_D=1, redirect=1, redirect_pc=0x3100 -> next pc_F=0x3100, bd_F=1; following cycle bd_F follows branch_D.
REQ-036 stall=1, redirect=1, exc_req=1, eret_req=1 same cycle -> pc_F=0x4180, bd_F=0, fetch_cnt+1.
REQ-037 eret_req=1, epc=0x3002 -> pc_F=0x3002, exccode_F=4, instr_F=0; epc=0x7000 -> exccode_F=4.
REQ-038 Reset asserted while pc_F=0x4180 and stall=1 -> pc_F=0x3000, bd_F=0, fetch_cnt=0 after one edge.

Source files
------------

// File: rtl/if_pc_unit.sv
// Instruction-fetch PC unit: next-PC selection, fetch address checking,
// delay-slot tracking and an advance counter for the F stage.
module if_pc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        branch_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  output logic [31:0] iaddr,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic [4:0]  exccode_F,
  output logic        bd_F,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CODE_W = 5;

  localparam logic [PC_W-1:0]   RESET_PC   = 32'h0000_3000;
  localparam logic [PC_W-1:0]   EXC_VECTOR = 32'h0000_4180;
  localparam logic [PC_W-1:0]   IM_LO      = 32'h0000_3000;
  localparam logic [PC_W-1:0]   IM_HI      = 32'h0000_6FFC;
  localparam logic [PC_W-1:0]   PC_STEP    = 32'd4;
  localparam logic [CODE_W-1:0] CODE_NONE  = 5'd0;
  localparam logic [CODE_W-1:0] CODE_ADEL  = 5'd4;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            bd_q;
  logic            bd_d;
  logic [PC_W-1:0] cnt_q;
  logic [PC_W-1:0] cnt_d;
  logic            advance;
  logic            addr_err;

  // Next-PC select; exception entry and ERET bypass the stall.
  always_comb begin
    pc_d    = pc_q;
    bd_d    = bd_q;
    advance = 1'b0;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      bd_d    = 1'b0;
      advance = 1'b1;
    end else if (eret_req) begin
      pc_d    = epc;
      bd_d    = 1'b0;
      advance = 1'b1;
    end else if (stall) begin
      pc_d    = pc_q;
      bd_d    = bd_q;
    end else if (redirect) begin
      pc_d    = redirect_pc;
      bd_d    = branch_D;
      advance = 1'b1;
    end else begin
      pc_d    = PC_W'(pc_q + PC_STEP);
      bd_d    = branch_D;
      advance = 1'b1;
    end
  end

  assign cnt_d = advance ? PC_W'(cnt_q + PC_W'(1)) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      bd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      bd_q  <= bd_d;
      cnt_q <= cnt_d;
    end
  end

  // Fetch address check against the word-aligned instruction memory window.
  always_comb begin
    addr_err = 1'b0;
    if ((pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI)) begin
      addr_err = 1'b1;
    end
  end

  assign pc_F      = pc_q;
  assign iaddr     = pc_q;
  assign bd_F      = bd_q;
  assign fetch_cnt = cnt_q;
  assign exccode_F = addr_err ? CODE_ADEL : CODE_NONE;
  assign instr_F   = addr_err ? '0 : instr_in;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit: stimulus pushes the expected post-edge state,
// a monitor pops and compares it one time unit after every rising edge.
module tb_if_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        branch_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] instr_in;
  logic [31:0] iaddr;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic [4:0]  exccode_F;
  logic        bd_F;
  logic [31:0] fetch_cnt;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] cnt;
    logic [4:0]  code;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  if_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .branch_D    (branch_D),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .instr_in    (instr_in),
    .iaddr       (iaddr),
    .pc_F        (pc_F),
    .instr_F     (instr_F),
    .exccode_F   (exccode_F),
    .bd_F        (bd_F),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %08h expected %08h", id, name, act, exp);
    end
  endtask

  // Monitor: every edge presents a new F-stage state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_F",      e.id, pc_F,              e.pc);
        chk("iaddr",     e.id, iaddr,             e.pc);
        chk("bd_F",      e.id, 32'(bd_F),         32'(e.bd));
        chk("fetch_cnt", e.id, fetch_cnt,         e.cnt);
        chk("exccode_F", e.id, 32'(exccode_F),    32'(e.code));
        chk("instr_F",   e.id, instr_F,           e.instr);
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                      input logic bdin, input logic exc, input logic eret, input logic [31:0] e_pc,
                      input logic [31:0] x_pc, input logic x_bd, input logic [31:0] x_cnt,
                      input logic [4:0] x_code);
    exp_t e;
    logic [31:0] w;
    @(negedge clk);
    w           = $urandom();
    reset       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    branch_D    = bdin;
    exc_req     = exc;
    eret_req    = eret;
    epc         = e_pc;
    instr_in    = w;
    step_id++;
    e.id    = step_id;
    e.pc    = x_pc;
    e.bd    = x_bd;
    e.cnt   = x_cnt;
    e.code  = x_code;
    e.instr = (x_code != 5'd0) ? 32'h0 : w;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    branch_D = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0; instr_in = '0;
    //   rst st rd rpc           bd exc er epc           pc            bd cnt code
    step(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3004, 0, 1,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3008, 0, 2,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_300C, 0, 3,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3010, 0, 4,  0);
    // stall beats redirect
    step(0, 1, 1, 32'h5000,     0, 0, 0, 32'h0,        32'h0000_3010, 0, 4,  0);
    step(0, 1, 1, 32'h5000,     0, 0, 0, 32'h0,        32'h0000_3010, 0, 4,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3014, 0, 5,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3018, 0, 6,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_301C, 0, 7,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3020, 0, 8,  0);
    // taken branch, then delay-slot flag tracks branch_D
    step(0, 0, 1, 32'h3100,     1, 0, 0, 32'h0,        32'h0000_3100, 1, 9,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3104, 0, 10, 0);
    step(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3108, 1, 11, 0);
    step(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3108, 1, 11, 0);
    // everything at once: exception wins
    step(0, 1, 1, 32'h3200,     1, 1, 1, 32'h3300,     32'h0000_4180, 0, 12, 0);
    // reset while stalled at the vector
    step(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    // ERET targets, including bad ones
    step(0, 1, 1, 32'h3400,     1, 0, 1, 32'h3002,     32'h0000_3002, 0, 1,  4);
    step(0, 0, 0, 32'h0,        0, 0, 1, 32'h7000,     32'h0000_7000, 0, 2,  4);
    step(0, 0, 0, 32'h0,        0, 0, 1, 32'h6FFC,     32'h0000_6FFC, 0, 3,  0);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_7000, 0, 4,  4);
    step(0, 0, 0, 32'h0,        0, 0, 1, 32'h2FFC,     32'h0000_2FFC, 0, 5,  4);
    // misaligned redirect still loads
    step(0, 0, 1, 32'h3001,     0, 0, 0, 32'h0,        32'h0000_3001, 0, 6,  4);
    step(0, 0, 1, 32'h3000,     1, 0, 0, 32'h0,        32'h0000_3000, 1, 7,  0);
    // PC wrap
    step(0, 0, 0, 32'h0,        0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 8, 4);
    step(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0000, 0, 9,  4);
    // reset overrides redirect and exception
    step(1, 0, 1, 32'h5000,     1, 1, 0, 32'h0,        32'h0000_3000, 0, 0,  0);
    step(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3004, 1, 1,  0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
